// File: rtl/store_unit_pkg.sv
// store_unit shared types: store width encoding, FSM states, lane helpers.
// Width codes match the low bits of funct3 for SB/SH/SW.
package store_unit_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SW_BYTE = 2'b00,
    SW_HALF = 2'b01,
    SW_WORD = 2'b10
  } store_width_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } su_state_e;

  // Reserved code 2'b11 is treated as a full word.
  function automatic logic [LANES-1:0] size_mask(store_width_e sz);
    logic [LANES-1:0] m;
    unique case (sz)
      SW_BYTE: m = 4'b0001;
      SW_HALF: m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_unit_if.sv
// store_unit bundle: Memory-stage store handshake plus data-memory write port.
// slave is the store unit side, master the pipeline/memory side.
interface store_unit_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  storeValid;
  logic                  storeReady;
  logic [ADDR_WIDTH-1:0] storeAddr;
  logic [XLEN-1:0]       storeData;
  logic [1:0]            storeSize;
  logic                  storeDone;
  logic                  storeMisaligned;
  logic                  busy;
  logic                  memReq;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [XLEN-1:0]       memWriteData;
  logic [3:0]            memByteEnable;
  logic                  memAck;

  modport slave (
    input  storeValid, storeAddr, storeData,
    input  storeSize, memAck,
    output storeReady, storeDone, storeMisaligned,
    output busy, memReq, memAddr,
    output memWriteData, memByteEnable
  );

  modport master (
    output storeValid, storeAddr, storeData,
    output storeSize, memAck,
    input  storeReady, storeDone, storeMisaligned,
    input  busy, memReq, memAddr,
    input  memWriteData, memByteEnable
  );

endinterface

// File: rtl/store_lane_align.sv
// Store lane alignment: places size-masked data and byte enables on a
// two-word (64-bit) window so a word-crossing store splits cleanly.
module store_lane_align
  import store_unit_pkg::*;
(
  input  logic [1:0]   off,
  input  store_width_e size,
  input  logic [31:0]  data,
  output logic [63:0]  data64,
  output logic [7:0]   lanes8,
  output logic         crossing
);

  logic [3:0]  mask;
  logic [31:0] dmask;

  always_comb begin
    mask     = size_mask(size);
    dmask    = {{8{mask[3]}}, {8{mask[2]}},
                {8{mask[1]}}, {8{mask[0]}}};
    lanes8   = {4'b0000, mask} << off;
    data64   = {32'h0, data & dmask} << {off, 3'b000};
    crossing = |lanes8[7:4];
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: turns SB/SH/SW into lane-aligned data-memory write beats,
// splitting word-crossing stores into two beats when allowed.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic      clk,
  input logic      reset_n,
  store_unit_if.slave bus
);

  su_state_e state_q, state_d;

  logic [63:0] data64;
  logic [7:0]  lanes8;
  logic        crossing;

  logic accept;
  logic reject;
  logic take;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [ADDR_WIDTH-1:0] addr_q, addr1_q;
  logic [XLEN-1:0]       data_q, data1_q;
  logic [3:0]            be_q, be1_q;
  logic                  cross_q;
  logic                  done_q;
  logic                  mis_q;

  store_lane_align u_align (
    .off      (bus.storeAddr[1:0]),
    .size     (store_width_e'(bus.storeSize)),
    .data     (bus.storeData[31:0]),
    .data64   (data64),
    .lanes8   (lanes8),
    .crossing (crossing)
  );

  assign accept    = bus.storeValid && (state_q == IDLE);
  assign reject    = accept && crossing && !ALLOW_MISALIGNED;
  assign take      = accept && !reject;
  assign word_addr = {bus.storeAddr[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    state_d             = state_q;
    bus.storeReady      = (state_q == IDLE);
    bus.busy            = (state_q != IDLE);
    bus.memReq          = (state_q != IDLE);
    bus.memAddr         = addr_q;
    bus.memWriteData    = data_q;
    bus.memByteEnable   = be_q;
    bus.storeDone       = done_q;
    bus.storeMisaligned = mis_q;
    unique case (state_q)
      IDLE: begin
        if (take) state_d = BEAT0;
      end
      BEAT0: begin
        if (bus.memAck) state_d = cross_q ? BEAT1 : IDLE;
      end
      BEAT1: begin
        if (bus.memAck) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      addr1_q <= '0;
      data1_q <= '0;
      be1_q   <= '0;
      cross_q <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= reject;
      unique case (state_q)
        IDLE: begin
          if (take) begin
            addr_q  <= word_addr;
            data_q  <= data64[31:0];
            be_q    <= lanes8[3:0];
            addr1_q <= word_addr + ADDR_WIDTH'(4);
            data1_q <= data64[63:32];
            be1_q   <= lanes8[7:4];
            cross_q <= crossing;
          end
        end
        BEAT0: begin
          if (bus.memAck && cross_q) begin
            addr_q <= addr1_q;
            data_q <= data1_q;
            be_q   <= be1_q;
          end else if (bus.memAck) begin
            addr_q <= '0;
            data_q <= '0;
            be_q   <= '0;
            done_q <= 1'b1;
          end
        end
        BEAT1: begin
          if (bus.memAck) begin
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            cross_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// store_unit bench: directed and random stores checked against a
// byte-by-byte memory model; a second instance runs with splitting disabled.
module tb_store_unit;
  import store_unit_pkg::*;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  store_unit_if #(.XLEN(32), .ADDR_WIDTH(32)) ia ();
  store_unit_if #(.XLEN(32), .ADDR_WIDTH(32)) im ();

  store_unit #(.XLEN(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ia)
  );

  store_unit #(.XLEN(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) dut_m (
    .clk(clk), .reset_n(reset_n), .bus(im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected beats of the current store
  int          nb;
  logic [31:0] b_addr [2];
  logic [31:0] b_data [2];
  logic [3:0]  b_be   [2];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory view: write each stored byte to its own address, group by word.
  task automatic model(input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] data);
    int          n;
    logic [31:0] a;
    logic [31:0] w;
    logic [1:0]  lane;
    n  = (size == SW_BYTE) ? 1 : (size == SW_HALF) ? 2 : 4;
    nb = 0;
    for (int i = 0; i < n; i++) begin
      a    = addr + 32'(i);
      w    = {a[31:2], 2'b00};
      lane = a[1:0];
      if (nb == 0 || b_addr[nb-1] != w) begin
        b_addr[nb] = w;
        b_data[nb] = 32'h0;
        b_be[nb]   = 4'h0;
        nb++;
      end
      b_data[nb-1][lane*8 +: 8] = data[i*8 +: 8];
      b_be[nb-1][lane]          = 1'b1;
    end
  endtask

  task automatic check_beat(input int b);
    chk("memReq",   64'(ia.memReq),        64'd1);
    chk("memAddr",  64'(ia.memAddr),       64'(b_addr[b]));
    chk("memData",  64'(ia.memWriteData),  64'(b_data[b]));
    chk("memBE",    64'(ia.memByteEnable), 64'(b_be[b]));
    chk("busy",     64'(ia.busy),          64'd1);
    chk("ready_bz", 64'(ia.storeReady),    64'd0);
    chk("done_bz",  64'(ia.storeDone),     64'd0);
  endtask

  // Called at a negedge with the unit idle; returns at the negedge
  // where storeDone is expected.
  task automatic run_store(input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] data, input int maxwait);
    int w;
    model(addr, size, data);
    chk("ready", 64'(ia.storeReady), 64'd1);
    ia.storeValid = 1'b1;
    ia.storeAddr  = addr;
    ia.storeSize  = size;
    ia.storeData  = data;
    @(negedge clk);
    ia.storeValid = 1'b0;
    ia.storeAddr  = $urandom;
    ia.storeData  = $urandom;
    for (int b = 0; b < nb; b++) begin
      w = (maxwait < 0) ? int'($urandom_range(0, 3)) : maxwait;
      for (int c = 0; c <= w; c++) begin
        check_beat(b);
        ia.memAck = (c == w);
        @(negedge clk);
        ia.memAck = 1'b0;
      end
    end
    chk("done",   64'(ia.storeDone),  64'd1);
    chk("req_lo", 64'(ia.memReq),     64'd0);
    chk("idle",   64'(ia.busy),       64'd0);
    chk("ready2", 64'(ia.storeReady), 64'd1);
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    reset_n        = 1'b0;
    ia.storeValid  = 1'b0;
    ia.storeAddr   = '0;
    ia.storeData   = '0;
    ia.storeSize   = 2'b00;
    ia.memAck      = 1'b0;
    im.storeValid  = 1'b0;
    im.storeAddr   = '0;
    im.storeData   = '0;
    im.storeSize   = 2'b00;
    im.memAck      = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_req",  64'(ia.memReq),          64'd0);
    chk("rst_busy", 64'(ia.busy),            64'd0);
    chk("rst_done", 64'(ia.storeDone),       64'd0);
    chk("rst_mis",  64'(im.storeMisaligned), 64'd0);
    chk("rst_addr", 64'(ia.memAddr),         64'd0);
    chk("rst_data", 64'(ia.memWriteData),    64'd0);
    chk("rst_be",   64'(ia.memByteEnable),   64'd0);
    chk("rst_rdy",  64'(ia.storeReady),      64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // ack while idle must do nothing
    ia.memAck = 1'b1;
    @(negedge clk);
    ia.memAck = 1'b0;
    chk("idle_ack_req",  64'(ia.memReq),    64'd0);
    chk("idle_ack_done", 64'(ia.storeDone), 64'd0);

    run_store(32'h100, SW_WORD, 32'hDEADBEEF, 0);
    run_store(32'h203, SW_BYTE, 32'h123456AB, 0);
    run_store(32'h302, SW_HALF, 32'h0000CAFE, 3);
    run_store(32'h403, SW_WORD, 32'h11223344, 1);
    chk("split_beats", 64'(nb), 64'd2);
    run_store(32'hFFFFFFFF, SW_HALF, 32'h0000BEEF, 0);
    chk("wrap_b1", 64'(b_addr[1]), 64'h0);

    // splitting disabled: crossing store is flagged and dropped
    im.storeValid = 1'b1;
    im.storeAddr  = 32'h403;
    im.storeSize  = SW_WORD;
    im.storeData  = 32'h11223344;
    @(negedge clk);
    im.storeValid = 1'b0;
    chk("mis_pulse", 64'(im.storeMisaligned), 64'd1);
    chk("mis_req",   64'(im.memReq),          64'd0);
    chk("mis_rdy",   64'(im.storeReady),      64'd1);
    @(negedge clk);
    chk("mis_once",  64'(im.storeMisaligned), 64'd0);
    chk("mis_req2",  64'(im.memReq),          64'd0);
    chk("mis_rdy2",  64'(im.storeReady),      64'd1);

    // aligned store still goes through with splitting disabled
    im.storeValid = 1'b1;
    im.storeAddr  = 32'h502;
    im.storeSize  = SW_HALF;
    im.storeData  = 32'h0000A55A;
    @(negedge clk);
    im.storeValid = 1'b0;
    chk("m_req",  64'(im.memReq),          64'd1);
    chk("m_addr", 64'(im.memAddr),         64'h500);
    chk("m_data", 64'(im.memWriteData),    64'hA55A0000);
    chk("m_be",   64'(im.memByteEnable),   64'hC);
    chk("m_mis",  64'(im.storeMisaligned), 64'd0);
    im.memAck = 1'b1;
    @(negedge clk);
    im.memAck = 1'b0;
    chk("m_done", 64'(im.storeDone), 64'd1);

    // reset during the second beat aborts the store
    model(32'h403, SW_WORD, 32'h11223344);
    ia.storeValid = 1'b1;
    ia.storeAddr  = 32'h403;
    ia.storeSize  = SW_WORD;
    ia.storeData  = 32'h11223344;
    @(negedge clk);
    ia.storeValid = 1'b0;
    check_beat(0);
    ia.memAck = 1'b1;
    @(negedge clk);
    ia.memAck = 1'b0;
    check_beat(1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_req",  64'(ia.memReq),     64'd0);
    chk("abort_busy", 64'(ia.busy),       64'd0);
    chk("abort_rdy",  64'(ia.storeReady), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("abort_nodone", 64'(ia.storeDone), 64'd0);
      @(negedge clk);
    end
    run_store(32'h0, SW_WORD, 32'h0BADF00D, -1);

    // randomized stores, back to back, random ack latency
    for (int i = 0; i < 40; i++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 2));
      run_store($urandom, sz, $urandom, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
